cpu7_ifu_fbuf: RTL and testbench

Parametrised fetch-request engine and instruction buffer for the next-generation cpu7 instruction fetch unit.
- Issues group-aligned fetch requests on the inst bus.
- Tracks up to MAX_OUTST outstanding requests and accepts up to FETCH_W instructions per response.
- Buffers instructions in a DEPTH-entry FIFO and presents one instruction per cycle to decode.
- Decouples fetch from decode stalls and handles redirect (branch/exception/ertn) flushes with response dropping.

---
 rtl/cpu7_ifu_fbuf_pkg.sv | 22 ++
 rtl/cpu7_ifu_fbuf_oaq.sv | 58 +++++
 rtl/cpu7_ifu_fbuf.sv | 166 ++++++++++++++++
 tb/tb_cpu7_ifu_fbuf.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu7_ifu_fbuf_pkg.sv
// Shared types and constants for the cpu7 fetch-request engine and instruction buffer.
package cpu7_ifu_fbuf_pkg;

    localparam int GRLEN       = 32;
    localparam int EXC_W       = 6;
    localparam int FETCH_W_DEF = 2;
    localparam int FETCH_BYTES = 4 * FETCH_W_DEF;

    // One buffered instruction as seen by decode.
    typedef struct packed {
        logic [GRLEN-1:0] inst;
        logic [GRLEN-1:0] pc;
        logic             ex;
        logic [EXC_W-1:0] exccode;
    } fetch_entry_t;

    // Byte size of a fetch group for a given group width.
    function automatic int fetch_bytes(input int fw);
        return 4 * fw;
    endfunction

endpackage

// File: rtl/cpu7_ifu_fbuf_oaq.sv
// Outstanding-address queue: remembers the PC of every accepted fetch request
// so the matching in-order response can be tagged with its address.
module cpu7_ifu_fbuf_oaq
    import cpu7_ifu_fbuf_pkg::*;
#(
    parameter int N = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [GRLEN-1:0] push_addr,
    input  logic             pop,
    output logic [GRLEN-1:0] head_addr,
    output logic [2:0]       count
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [GRLEN-1:0] addr_mem [N];
    logic [PW-1:0]    wr_ptr_reg;
    logic [PW-1:0]    rd_ptr_reg;
    logic [2:0]       count_reg;
    logic             push_ok;
    logic             pop_ok;

    // Wrap a pointer at N, which need not be a power of two.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(N - 1)) ? '0 : p + 1'b1;
    endfunction

    // Guard against popping empty or pushing full; the top never does either.
    always_comb begin
        pop_ok  = pop & (count_reg != 3'd0);
        push_ok = push & ((int'(count_reg) < N) | pop_ok);
    end

    // Pointer and occupancy bookkeeping; only reset clears the queue.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= next_ptr(wr_ptr_reg);
            if (pop_ok)  rd_ptr_reg <= next_ptr(rd_ptr_reg);
            count_reg <= count_reg + {2'b0, push_ok} - {2'b0, pop_ok};
        end
    end

    // Address storage needs no reset; entries are only read when valid.
    always_ff @(posedge clk) begin
        if (push_ok) addr_mem[wr_ptr_reg] <= push_addr;
    end

    assign head_addr = addr_mem[rd_ptr_reg];
    assign count     = count_reg;

endmodule

// File: rtl/cpu7_ifu_fbuf.sv
// cpu7 IFU fetch-request engine plus instruction buffer. Requests are issued
// only when the buffer can absorb a full group for every request in flight,
// so the buffer can never overflow. Redirects flush the buffer and mark all
// in-flight requests stale; their responses are dropped as they come back.
module cpu7_ifu_fbuf
    import cpu7_ifu_fbuf_pkg::*;
#(
    parameter int FETCH_W   = FETCH_BYTES / 4,
    parameter int DEPTH     = 8,
    parameter int MAX_OUTST = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [31:0]             pc_init,
    input  logic                    redirect,
    input  logic [31:0]             redirect_pc,
    output logic                    inst_req,
    output logic [31:0]             inst_addr,
    input  logic                    inst_addr_ok,
    output logic                    inst_cancel,
    input  logic                    inst_valid_f,
    input  logic [2:0]              inst_count,
    input  logic [32*FETCH_W-1:0]   inst_rdata_f,
    input  logic                    inst_ex,
    input  logic [5:0]              inst_exccode,
    input  logic                    deq_ready,
    output logic                    fbuf_vld_d,
    output logic [31:0]             fbuf_inst_d,
    output logic [31:0]             fbuf_pc_d,
    output logic                    fbuf_ex_d,
    output logic [5:0]              fbuf_exccode_d,
    output logic [$clog2(DEPTH):0]  fbuf_count
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int GROUP_B = fetch_bytes(FETCH_W);
    localparam logic [GRLEN-1:0] GROUP_MASK = ~(GRLEN'(GROUP_B - 1));

    fetch_entry_t     buf_mem [DEPTH];
    fetch_entry_t     lane_entry [FETCH_W];
    fetch_entry_t     head;
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic [GRLEN-1:0] fetch_pc_reg;
    logic [2:0]       drop_cnt_reg;
    logic             halt_reg;

    logic [2:0]       outstanding;
    logic [2:0]       outstanding_eff;
    logic [GRLEN-1:0] resp_pc;
    logic             credit_ok;
    logic             issue;
    logic             resp_pop;
    logic             drop_active;
    logic             accept_resp;
    logic             deq;
    logic [2:0]       lane_n;
    logic [CNT_W-1:0] enq_n;
    logic             unused_bits;

    assign unused_bits = ^{pc_init[1:0], redirect_pc[1:0]};

    cpu7_ifu_fbuf_oaq #(
        .N (MAX_OUTST)
    ) u_oaq (
        .clk       (clk),
        .reset     (reset),
        .push      (issue),
        .push_addr (fetch_pc_reg),
        .pop       (resp_pop),
        .head_addr (resp_pc),
        .count     (outstanding)
    );

    // Build the candidate entry for every response lane; an exception
    // response carries only lane 0 with the instruction word zeroed.
    for (genvar gi = 0; gi < FETCH_W; gi++) begin : g_lane
        assign lane_entry[gi] = '{
            inst:    inst_ex ? '0 : inst_rdata_f[32*gi +: 32],
            pc:      resp_pc + GRLEN'(4 * gi),
            ex:      inst_ex,
            exccode: inst_ex ? inst_exccode : '0
        };
    end

    // Request credit, response acceptance and dequeue decisions.
    always_comb begin
        // Each outstanding request reserves a full group of buffer space.
        credit_ok = (DEPTH - int'(count_reg) - FETCH_W * int'(outstanding)) >= FETCH_W;
        inst_req  = ~reset & ~redirect & ~halt_reg &
                    (int'(outstanding) < MAX_OUTST) & credit_ok;
        issue     = inst_req & inst_addr_ok;

        resp_pop        = inst_valid_f & (outstanding != 3'd0);
        outstanding_eff = outstanding - {2'b0, resp_pop};
        drop_active     = (drop_cnt_reg != 3'd0);
        accept_resp     = inst_valid_f & ~redirect & ~drop_active;

        lane_n = (int'(inst_count) > FETCH_W) ? 3'(FETCH_W) : inst_count;
        if (!accept_resp)
            enq_n = '0;
        else if (inst_ex)
            enq_n = CNT_W'(1);
        else
            enq_n = CNT_W'(lane_n);

        fbuf_vld_d  = (count_reg != '0);
        deq         = fbuf_vld_d & deq_ready;
        inst_cancel = ~reset & redirect & (outstanding_eff != 3'd0);
        inst_addr   = reset ? '0 : fetch_pc_reg;
    end

    // Control state: fetch PC, FIFO pointers, stale-response counter, halt.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_reg <= {pc_init[31:2], 2'b00};
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            drop_cnt_reg <= '0;
            halt_reg     <= 1'b0;
        end else if (redirect) begin
            fetch_pc_reg <= {redirect_pc[31:2], 2'b00};
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            halt_reg     <= 1'b0;
            // Every request still in flight is stale now, including ones
            // already counted from an earlier redirect, so the counter is
            // set to the in-flight total rather than accumulated.
            drop_cnt_reg <= outstanding_eff;
        end else begin
            wr_ptr_reg <= wr_ptr_reg + PTR_W'(enq_n);
            rd_ptr_reg <= rd_ptr_reg + PTR_W'(deq);
            count_reg  <= count_reg + enq_n - CNT_W'(deq);
            if (issue)
                fetch_pc_reg <= (fetch_pc_reg & GROUP_MASK) + GRLEN'(GROUP_B);
            if (accept_resp && inst_ex)
                halt_reg <= 1'b1;
            if (inst_valid_f && drop_active)
                drop_cnt_reg <= drop_cnt_reg - 3'd1;
        end
    end

    // Buffer storage: up to FETCH_W consecutive slots written per response.
    always_ff @(posedge clk) begin
        for (int i = 0; i < FETCH_W; i++) begin
            if (CNT_W'(i) < enq_n)
                buf_mem[wr_ptr_reg + PTR_W'(i)] <= lane_entry[i];
        end
    end

    // Head entry, forced to zero while the buffer is empty.
    always_comb begin
        head           = buf_mem[rd_ptr_reg];
        fbuf_inst_d    = fbuf_vld_d ? head.inst    : '0;
        fbuf_pc_d      = fbuf_vld_d ? head.pc      : '0;
        fbuf_ex_d      = fbuf_vld_d ? head.ex      : 1'b0;
        fbuf_exccode_d = fbuf_vld_d ? head.exccode : '0;
    end

    assign fbuf_count = count_reg;

endmodule

// File: tb/tb_cpu7_ifu_fbuf.sv
// Bench for cpu7_ifu_fbuf: an in-order bus model with random latency plus a
// queue-based reference of the buffer contents, checked every cycle.
module tb_cpu7_ifu_fbuf;

    localparam int FW    = 2;
    localparam int DEPTH = 8;
    localparam int MO    = 2;
    localparam logic [31:0] PC_INIT = 32'h1C00_0000;

    logic                 clk;
    logic                 reset;
    logic [31:0]          pc_init;
    logic                 redirect;
    logic [31:0]          redirect_pc;
    logic                 inst_req;
    logic [31:0]          inst_addr;
    logic                 inst_addr_ok;
    logic                 inst_cancel;
    logic                 inst_valid_f;
    logic [2:0]           inst_count;
    logic [32*FW-1:0]     inst_rdata_f;
    logic                 inst_ex;
    logic [5:0]           inst_exccode;
    logic                 deq_ready;
    logic                 fbuf_vld_d;
    logic [31:0]          fbuf_inst_d;
    logic [31:0]          fbuf_pc_d;
    logic                 fbuf_ex_d;
    logic [5:0]           fbuf_exccode_d;
    logic [$clog2(DEPTH):0] fbuf_count;

    cpu7_ifu_fbuf #(
        .FETCH_W   (FW),
        .DEPTH     (DEPTH),
        .MAX_OUTST (MO)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .pc_init        (pc_init),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .inst_req       (inst_req),
        .inst_addr      (inst_addr),
        .inst_addr_ok   (inst_addr_ok),
        .inst_cancel    (inst_cancel),
        .inst_valid_f   (inst_valid_f),
        .inst_count     (inst_count),
        .inst_rdata_f   (inst_rdata_f),
        .inst_ex        (inst_ex),
        .inst_exccode   (inst_exccode),
        .deq_ready      (deq_ready),
        .fbuf_vld_d     (fbuf_vld_d),
        .fbuf_inst_d    (fbuf_inst_d),
        .fbuf_pc_d      (fbuf_pc_d),
        .fbuf_ex_d      (fbuf_ex_d),
        .fbuf_exccode_d (fbuf_exccode_d),
        .fbuf_count     (fbuf_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        ex;
        logic [5:0]  code;
    } ent_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          stale;
    } oreq_t;

    // Reference state: expected decode-side queue and in-flight requests.
    ent_t        m_fifo[$];
    oreq_t       m_oq[$];
    logic [31:0] m_pc;
    bit          m_halt;
    int          cyc;

    int n_checks;
    int n_pass;
    int n_fail;

    // Stimulus knobs (percent probabilities and maximum bus latency).
    int p_deq, p_ok, p_resp, p_redir, p_ex, p_odd, lat_max;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_fifo.delete();
        m_oq.delete();
        m_pc   = PC_INIT;
        m_halt = 1'b0;
    endtask

    task automatic idle_inputs();
        redirect     = 1'b0;
        redirect_pc  = '0;
        inst_addr_ok = 1'b0;
        inst_valid_f = 1'b0;
        inst_count   = '0;
        inst_rdata_f = '0;
        inst_ex      = 1'b0;
        inst_exccode = '0;
        deq_ready    = 1'b0;
    endtask

    // Assert reset between edges and check that every output clears at once.
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        idle_inputs();
        #1;
        check("rst_inst_req",    inst_req,       '0);
        check("rst_inst_addr",   inst_addr,      '0);
        check("rst_inst_cancel", inst_cancel,    '0);
        check("rst_fbuf_vld",    fbuf_vld_d,     '0);
        check("rst_fbuf_inst",   fbuf_inst_d,    '0);
        check("rst_fbuf_pc",     fbuf_pc_d,      '0);
        check("rst_fbuf_ex",     fbuf_ex_d,      '0);
        check("rst_fbuf_code",   fbuf_exccode_d, '0);
        check("rst_fbuf_count",  fbuf_count,     '0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    // One clock cycle: drive random inputs, compare, then advance the model.
    task automatic step();
        bit          rsp;
        bit          exp_req;
        int          eff;
        int          n;
        oreq_t       o;
        logic [31:0] rpc;
        @(negedge clk);
        cyc++;
        deq_ready    = ($urandom_range(99) < p_deq);
        inst_addr_ok = ($urandom_range(99) < p_ok);
        redirect     = ($urandom_range(99) < p_redir);
        redirect_pc  = 32'h1C00_0100 + 32'($urandom_range(63)) * 4 + 32'($urandom_range(3));
        rsp = (m_oq.size() > 0) && (cyc >= m_oq[0].due) && ($urandom_range(99) < p_resp);
        inst_valid_f = rsp;
        inst_ex      = 1'b0;
        inst_exccode = 6'($urandom);
        inst_count   = 3'($urandom);
        inst_rdata_f = {$urandom, $urandom};
        if (rsp) begin
            rpc = m_oq[0].addr;
            if ($urandom_range(99) < p_odd)
                inst_count = 3'($urandom_range(7));
            else
                inst_count = 3'(FW - int'((rpc >> 2) % FW));
            inst_ex = ($urandom_range(99) < p_ex);
            for (int i = 0; i < FW; i++)
                inst_rdata_f[32*i +: 32] = inst_of(rpc + 32'(4 * i));
        end
        #1;
        exp_req = !redirect && !m_halt && (m_oq.size() < MO) &&
                  (DEPTH - m_fifo.size() - FW * m_oq.size() >= FW);
        eff = m_oq.size() - int'(rsp);
        check("inst_req",    inst_req,    exp_req);
        check("inst_addr",   inst_addr,   m_pc);
        check("inst_cancel", inst_cancel, redirect && (eff > 0));
        check("fbuf_vld",    fbuf_vld_d,  m_fifo.size() != 0);
        check("fbuf_count",  fbuf_count,  m_fifo.size());
        check("no_overflow", fbuf_count <= DEPTH, 1'b1);
        if (m_fifo.size() != 0) begin
            check("fbuf_pc",   fbuf_pc_d,      m_fifo[0].pc);
            check("fbuf_inst", fbuf_inst_d,    m_fifo[0].inst);
            check("fbuf_ex",   fbuf_ex_d,      m_fifo[0].ex);
            check("fbuf_code", fbuf_exccode_d, m_fifo[0].code);
        end

        // Decode takes the head first; fresh entries append behind it.
        if (!redirect && (m_fifo.size() > 0) && deq_ready)
            void'(m_fifo.pop_front());
        if (rsp) begin
            o = m_oq.pop_front();
            if (!redirect && !o.stale) begin
                if (inst_ex) begin
                    m_fifo.push_back('{inst: 32'h0, pc: o.addr, ex: 1'b1, code: inst_exccode});
                    m_halt = 1'b1;
                end else begin
                    n = (int'(inst_count) > FW) ? FW : int'(inst_count);
                    for (int i = 0; i < n; i++)
                        m_fifo.push_back('{inst: inst_of(o.addr + 32'(4 * i)),
                                           pc: o.addr + 32'(4 * i), ex: 1'b0, code: 6'h0});
                end
            end
        end
        if (exp_req && inst_addr_ok) begin
            m_oq.push_back('{addr: m_pc, due: cyc + 1 + $urandom_range(lat_max - 1), stale: 1'b0});
            m_pc = (m_pc & ~32'(4 * FW - 1)) + 32'(4 * FW);
        end
        if (redirect) begin
            m_fifo.delete();
            foreach (m_oq[i]) m_oq[i].stale = 1'b1;
            m_pc   = redirect_pc & ~32'h3;
            m_halt = 1'b0;
        end
    endtask

    task automatic set_knobs(input int d, input int ok, input int r, input int rd,
                             input int ex, input int odd, input int lat);
        p_deq = d; p_ok = ok; p_resp = r; p_redir = rd; p_ex = ex; p_odd = odd; lat_max = lat;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        n_fail   = 0;
        cyc      = 0;
        pc_init  = PC_INIT;
        reset    = 1'b1;
        idle_inputs();
        model_reset();

        do_reset();

        // Streaming fetch: one-cycle bus, decode always ready.
        set_knobs(100, 100, 100, 0, 0, 0, 1);
        repeat (40) step();

        // Decode stalled until the credit limit holds requests, then drain.
        set_knobs(0, 100, 100, 0, 0, 0, 3);
        repeat (30) step();
        set_knobs(100, 100, 100, 0, 0, 0, 3);
        repeat (30) step();

        // Mixed traffic with redirects, exceptions and odd counts.
        set_knobs(60, 70, 70, 5, 3, 10, 4);
        repeat (2000) step();

        // Redirect-heavy traffic to exercise stale-response dropping.
        set_knobs(70, 80, 60, 25, 5, 5, 4);
        repeat (600) step();

        // Fill up with decode stalled, then reset in the middle of it.
        set_knobs(0, 100, 50, 0, 0, 0, 3);
        for (int k = 0; k < 200; k++) begin
            if ((m_fifo.size() >= 3) && (m_oq.size() >= 1)) break;
            step();
        end
        do_reset();
        set_knobs(100, 100, 100, 0, 0, 0, 1);
        repeat (40) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
